// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the BAMSE interrupt controller: register offsets,
// FSM encoding and ID-register layout.
package irq_ctrl_pkg;

  localparam logic [7:0] OFS_PEND = 8'd0;
  localparam logic [7:0] OFS_MASK = 8'd1;
  localparam logic [7:0] OFS_ID   = 8'd2;

  // Bit of the ID register that reads 1 while a request is being serviced
  localparam int ID_ACTIVE_BIT = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Ones in the low n bits; marks which pend/mask bits physically exist
  function automatic logic [7:0] impl_bits(input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit encoder over 8 request bits; bit 0 has top priority.
module irq_prio_enc (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the top down so the lowest set bit is the last assignment
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl_bamse.sv
// Interrupt controller between the BAMSE peripherals and the PicoBlaze
// interrupt pin: edge-latched pending bits, mask, priority select and a
// single-level interrupt/ack/EOI handshake, with PEND/MASK/ID on the port bus.
module irq_ctrl_bamse
  import irq_ctrl_pkg::*;
#(
  parameter logic [7:0] ADDR    = 8'h10,
  parameter int         NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         address,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  input  logic               ren,
  input  logic               wen,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               interrupt,
  input  logic               interrupt_ack
);

  localparam logic [7:0] IMPL = impl_bits(NUM_IRQ);

  irq_state_e state, state_nxt;
  logic [7:0] pend, mask, irq_prev, irq_ext, rise;
  logic [7:0] ack_clr, w1c_clr;
  logic [2:0] id, id_nxt, win_idx;
  logic       win_vld, int_nxt;
  logic       sel_pend, sel_mask, sel_id, eoi, ack;

  // Widen the request lines to the 8-bit register width
  always_comb begin
    irq_ext = '0;
    irq_ext[NUM_IRQ-1:0] = irq_in;
  end

  assign rise     = irq_ext & ~irq_prev & IMPL;
  assign sel_pend = (address == ADDR + OFS_PEND);
  assign sel_mask = (address == ADDR + OFS_MASK);
  assign sel_id   = (address == ADDR + OFS_ID);
  assign eoi      = wen && sel_id && (state == SERVICE);
  assign ack      = interrupt_ack && (state == REQ);
  assign w1c_clr  = (wen && sel_pend) ? data_in : 8'h00;
  assign ack_clr  = ack ? (8'h01 << id) : 8'h00;

  irq_prio_enc u_prio (
    .req   (pend & mask),
    .valid (win_vld),
    .idx   (win_idx)
  );

  // Pending/mask/edge-history registers; a fresh rise beats any clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      mask     <= '0;
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_ext & IMPL;
      pend     <= ((pend & ~w1c_clr & ~ack_clr) | rise) & IMPL;
      if (wen && sel_mask) mask <= data_in & IMPL;
    end
  end

  // Registered read port; drives zero when not selected so it can be OR-ed
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (ren && sel_pend) begin
      data_out <= pend;
    end else if (ren && sel_mask) begin
      data_out <= mask;
    end else if (ren && sel_id) begin
      data_out <= '0;
      data_out[ID_ACTIVE_BIT] <= (state == SERVICE);
      data_out[2:0] <= id;
    end else begin
      data_out <= '0;
    end
  end

  // FSM state, latched winner and CPU request line
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      id        <= '0;
      interrupt <= 1'b0;
    end else begin
      state     <= state_nxt;
      id        <= id_nxt;
      interrupt <= int_nxt;
    end
  end

  // Handshake: the winner is only captured in IDLE, so later mask/pend
  // changes never retract a request already presented to the CPU
  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    int_nxt   = interrupt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = REQ;
          id_nxt    = win_idx;
          int_nxt   = 1'b1;
        end
      end
      REQ: begin
        if (ack) begin
          state_nxt = SERVICE;
          int_nxt   = 1'b0;
        end
      end
      SERVICE: begin
        int_nxt = 1'b0;
        if (eoi) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        int_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl_bamse.sv
// Directed bench for irq_ctrl_bamse with a small timer model on irq_in[0].
module tb_irq_ctrl_bamse;

  localparam logic [7:0] A_PEND = 8'h10;
  localparam logic [7:0] A_MASK = 8'h11;
  localparam logic [7:0] A_ID   = 8'h12;

  logic       clk = 1'b0;
  logic       rst, ren, wen, interrupt_ack, interrupt;
  logic [7:0] address, data_in, data_out, irq_drv, irq_in;

  // Timer model: prescaler 3 (one count per 4 clocks), int flag on rollover
  logic        t_run, t_clr, tflag;
  logic [15:0] t_cnt;
  logic [1:0]  t_pre;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign irq_in = irq_drv | {7'b0, tflag};

  always @(posedge clk) begin
    if (t_clr) begin
      tflag <= 1'b0;
      t_cnt <= 16'hfff0;
      t_pre <= 2'd0;
    end else if (t_run) begin
      if (t_pre == 2'd3) begin
        t_pre <= 2'd0;
        t_cnt <= t_cnt + 16'd1;
        if (t_cnt == 16'hffff) tflag <= 1'b1;
      end else begin
        t_pre <= t_pre + 2'd1;
      end
    end
  end

  irq_ctrl_bamse #(.ADDR(8'h10), .NUM_IRQ(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .ren           (ren),
    .wen           (wen),
    .irq_in        (irq_in),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a; data_in = d; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    address = a; ren = 1'b1;
    tick();
    ren = 1'b0;
    chk(tag, data_out, exp);
  endtask

  task automatic ack_cycle();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; ren = 0; wen = 0; interrupt_ack = 0;
    address = 8'h00; data_in = 8'h00; irq_drv = 8'h00;
    t_run = 0; t_clr = 1;
    tick(); tick();
    rst = 1'b0; t_clr = 0;
    chk("rst_int", {7'b0, interrupt}, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    rd("rst_pend", A_PEND, 8'h00);
    rd("rst_mask", A_MASK, 8'h00);
    rd("rst_id", A_ID, 8'h00);

    // 1: single source, full handshake
    wr(A_MASK, 8'h01);
    irq_drv = 8'h01;
    tick();
    chk("t1_int_k", {7'b0, interrupt}, 8'h00);
    tick();
    chk("t1_int_k1", {7'b0, interrupt}, 8'h01);
    rd("t1_pend", A_PEND, 8'h01);
    irq_drv = 8'h00;
    ack_cycle();
    chk("t1_int_ack", {7'b0, interrupt}, 8'h00);
    rd("t1_pend_ack", A_PEND, 8'h00);
    rd("t1_id_svc", A_ID, 8'h80);
    wr(A_ID, 8'h5a);
    rd("t1_id_eoi", A_ID, 8'h00);
    chk("t1_dout_idle", data_out, 8'h00);

    // 2: two simultaneous sources, priority order
    wr(A_MASK, 8'h06);
    irq_drv = 8'h06;
    tick(); tick();
    chk("t2_int", {7'b0, interrupt}, 8'h01);
    rd("t2_id_req", A_ID, 8'h01);
    ack_cycle();
    rd("t2_id_svc1", A_ID, 8'h81);
    wr(A_ID, 8'h00);
    chk("t2_int_eoi", {7'b0, interrupt}, 8'h00);
    tick();
    chk("t2_int_re", {7'b0, interrupt}, 8'h01);
    ack_cycle();
    rd("t2_id_svc2", A_ID, 8'h82);
    wr(A_ID, 8'h00);
    rd("t2_pend", A_PEND, 8'h00);
    irq_drv = 8'h00;

    // 3: masked source pends, unmasking raises the request
    wr(A_MASK, 8'h00);
    irq_drv = 8'h08;
    tick();
    rd("t3_pend", A_PEND, 8'h08);
    chk("t3_int_masked", {7'b0, interrupt}, 8'h00);
    wr(A_MASK, 8'h08);
    chk("t3_int_m", {7'b0, interrupt}, 8'h00);
    tick();
    chk("t3_int_m1", {7'b0, interrupt}, 8'h01);
    ack_cycle();
    wr(A_ID, 8'h00);
    irq_drv = 8'h00;

    // 4: set beats W1C on the same edge
    wr(A_MASK, 8'h00);
    irq_drv = 8'h10;
    tick();
    irq_drv = 8'h00;
    tick();
    irq_drv = 8'h10;
    wr(A_PEND, 8'h10);
    rd("t4_pend_race", A_PEND, 8'h10);
    wr(A_PEND, 8'h10);
    rd("t4_pend_clr", A_PEND, 8'h00);
    irq_drv = 8'h00;
    tick();

    // 5: timer rollover as a level source
    wr(A_MASK, 8'h01);
    t_run = 1'b1;
    n = 0;
    while (!interrupt && n < 300) begin tick(); n++; end
    chk("t5_int_timer", {7'b0, interrupt}, 8'h01);
    chk("t5_flag", {7'b0, tflag}, 8'h01);
    t_run = 1'b0;
    ack_cycle();
    wr(A_ID, 8'h00);
    tick(); tick(); tick();
    chk("t5_no_rereq", {7'b0, interrupt}, 8'h00);
    rd("t5_pend_held", A_PEND, 8'h00);
    t_clr = 1'b1; tick(); t_clr = 1'b0;
    t_run = 1'b1;
    n = 0;
    while (!interrupt && n < 300) begin tick(); n++; end
    chk("t5_int_again", {7'b0, interrupt}, 8'h01);
    t_run = 1'b0;

    // 6: reset in REQ with irq_in[0] held high
    chk("t6_in_req", {7'b0, interrupt}, 8'h01);
    rst = 1'b1;
    tick();
    chk("t6_int_rst", {7'b0, interrupt}, 8'h00);
    chk("t6_dout_rst", data_out, 8'h00);
    rst = 1'b0;
    rd("t6_mask", A_MASK, 8'h00);
    rd("t6_pend", A_PEND, 8'h01);
    rd("t6_id", A_ID, 8'h00);
    chk("t6_int", {7'b0, interrupt}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
